// File: rtl/ascon_serial_host_if.sv
// Bundles the parallel host-side signals and the bit-serial core-side signals of ascon_serial_host.
// Handshake: start is taken only while busy=0; done is a one-cycle pulse and results hold until the next accepted start; ready_si is only looked at while waiting on the core.
interface ascon_serial_host_if #(
  parameter int KEY_W = 128,
  parameter int BLK_W = 64
);
  logic             start;
  logic             decrypt;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] nonce;
  logic [BLK_W-1:0] ad;
  logic [BLK_W-1:0] din;
  logic             busy;
  logic             done;
  logic             err;
  logic [BLK_W-1:0] dout;
  logic [KEY_W-1:0] tag;
  logic             key_so;
  logic             nonce_so;
  logic             ad_so;
  logic             data_so;
  logic             start_so;
  logic             decrypt_so;
  logic             data_si;
  logic             tag_si;
  logic             ready_si;

  // master is the environment around the host: the controller plus the serial core.
  modport master (
    output start, decrypt, key, nonce, ad, din, data_si, tag_si, ready_si,
    input  busy, done, err, dout, tag,
    input  key_so, nonce_so, ad_so, data_so, start_so, decrypt_so
  );

  modport slave (
    input  start, decrypt, key, nonce, ad, din, data_si, tag_si, ready_si,
    output busy, done, err, dout, tag,
    output key_so, nonce_so, ad_so, data_so, start_so, decrypt_so
  );
endinterface

// File: rtl/ascon_serial_host.sv
// Serialises key/nonce/ad/data MSB-first to a bit-serial Ascon core, pulses its start,
// waits for ready (with timeout) and deserialises the returned data and tag.
module ascon_serial_host #(
  parameter int KEY_W   = 128,
  parameter int BLK_W   = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  ascon_serial_host_if.slave   bus,
  output logic [2:0]           dbg_state
);
  localparam int CW = $clog2(KEY_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    tcnt;
  logic [KEY_W-1:0] key_sr;
  logic [KEY_W-1:0] nonce_sr;
  logic [BLK_W-1:0] ad_sr;
  logic [BLK_W-1:0] din_sr;
  logic             decr_r;
  logic             err_r;
  logic [BLK_W-1:0] dout_r;
  logic [KEY_W-1:0] tag_r;

  // Operand shift registers empty themselves with zeros, so the shorter blocks
  // naturally read 0 once their BLK_W bits have gone out.
  assign bus.key_so     = (state == S_SHIFT) & key_sr[KEY_W-1];
  assign bus.nonce_so   = (state == S_SHIFT) & nonce_sr[KEY_W-1];
  assign bus.ad_so      = (state == S_SHIFT) & ad_sr[BLK_W-1];
  assign bus.data_so    = (state == S_SHIFT) & din_sr[BLK_W-1];
  assign bus.start_so   = (state == S_START);
  assign bus.decrypt_so = decr_r;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.err        = err_r;
  assign bus.dout       = dout_r;
  assign bus.tag        = tag_r;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tcnt     <= '0;
      key_sr   <= '0;
      nonce_sr <= '0;
      ad_sr    <= '0;
      din_sr   <= '0;
      decr_r   <= 1'b0;
      err_r    <= 1'b0;
      dout_r   <= '0;
      tag_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            key_sr   <= bus.key;
            nonce_sr <= bus.nonce;
            ad_sr    <= bus.ad;
            din_sr   <= bus.din;
            decr_r   <= bus.decrypt;
            err_r    <= 1'b0;
            dout_r   <= '0;
            tag_r    <= '0;
            cnt      <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          key_sr   <= key_sr << 1;
          nonce_sr <= nonce_sr << 1;
          ad_sr    <= ad_sr << 1;
          din_sr   <= din_sr << 1;
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(KEY_W - 1)) state <= S_START;
        end
        S_START: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ready_si) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (tcnt == TW'(TIMEOUT - 1)) begin
              err_r <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_CAPTURE: begin
          tag_r <= {tag_r[KEY_W-2:0], bus.tag_si};
          if (cnt < CW'(BLK_W)) dout_r <= {dout_r[BLK_W-2:0], bus.data_si};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(KEY_W - 1)) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_serial_host.sv
// Bench for ascon_serial_host: a cycle-counting core model drives the serial side and
// checks streams, pulse timing and returned words against values derived from the operands.
module tb_ascon_serial_host;
  localparam int KEY_W   = 128;
  localparam int BLK_W   = 64;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  ascon_serial_host_if #(.KEY_W(KEY_W), .BLK_W(BLK_W)) bus ();

  ascon_serial_host #(.KEY_W(KEY_W), .BLK_W(BLK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [KEY_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic logic [KEY_W-1:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [BLK_W-1:0] rnd_blk();
    return {$urandom, $urandom};
  endfunction

  // Called at a negedge; the operands and start are sampled at the next rising edge (T).
  // Cycle c is the c-th cycle after T. d<0 means the core never raises ready.
  task automatic run_txn(input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] n,
                         input logic [BLK_W-1:0] a, input logic [BLK_W-1:0] dn,
                         input bit dec, input int d,
                         input logic [BLK_W-1:0] rd, input logic [KEY_W-1:0] rt,
                         input int repulse_c, input bit hold);
    logic [KEY_W-1:0] key_st, nonce_st, ad_st, data_st, dret;
    logic [KEY_W-1:0] e_dout, e_tag;
    int exp_done, done_c, n_done, n_start_so, start_so_c, dec_bad, busy_bad, ser_bad, j;
    bit exp_err;
    key_st = '0; nonce_st = '0; ad_st = '0; data_st = '0;
    done_c = 0; n_done = 0; n_start_so = 0; start_so_c = 0;
    dec_bad = 0; busy_bad = 0; ser_bad = 0;
    exp_err  = (d < 0);
    exp_done = exp_err ? (KEY_W + 2 + TIMEOUT) : (2 * KEY_W + 3 + d);
    exp_q.push_back(exp_err ? '0 : {{(KEY_W-BLK_W){1'b0}}, rd});
    exp_q.push_back(exp_err ? '0 : rt);
    dret = rnd_key();
    dret[KEY_W-1 -: BLK_W] = rd;
    bus.key = k; bus.nonce = n; bus.ad = a; bus.din = dn;
    bus.decrypt = dec; bus.start = 1'b1;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      if (c <= KEY_W) begin
        key_st   = {key_st[KEY_W-2:0], bus.key_so};
        nonce_st = {nonce_st[KEY_W-2:0], bus.nonce_so};
        ad_st    = {ad_st[KEY_W-2:0], bus.ad_so};
        data_st  = {data_st[KEY_W-2:0], bus.data_so};
      end else if (bus.key_so | bus.nonce_so | bus.ad_so | bus.data_so) begin
        ser_bad++;
      end
      if (bus.start_so) begin n_start_so++; start_so_c = c; end
      if (bus.decrypt_so !== dec) dec_bad++;
      if (c <= exp_done && bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) begin n_done++; if (done_c == 0) done_c = c; end
      if (c == 1) check("err_cleared_on_start", {127'b0, bus.err}, '0);
      if (c == exp_done) begin
        e_dout = exp_q.pop_front();
        e_tag  = exp_q.pop_front();
        check("dout", {{(KEY_W-BLK_W){1'b0}}, bus.dout}, e_dout);
        check("tag", bus.tag, e_tag);
        check("err", {127'b0, bus.err}, {127'b0, exp_err});
      end
      if (c == exp_done + 1) check("busy_after_done", {127'b0, bus.busy}, '0);
      if (!hold) bus.start = (c == repulse_c);
      if (c < KEY_W + 2) bus.ready_si = 1'($urandom_range(0, 1));
      else bus.ready_si = (d >= 0) && (c == KEY_W + 2 + d);
      if (d >= 0 && c >= KEY_W + 3 + d && c <= 2 * KEY_W + 2 + d) begin
        j = c - (KEY_W + 3 + d);
        bus.data_si = dret[KEY_W-1-j];
        bus.tag_si  = rt[KEY_W-1-j];
      end else begin
        bus.data_si = 1'($urandom_range(0, 1));
        bus.tag_si  = 1'($urandom_range(0, 1));
      end
    end
    check("key_stream", key_st, k);
    check("nonce_stream", nonce_st, n);
    check("ad_stream", ad_st, {a, {(KEY_W-BLK_W){1'b0}}});
    check("data_stream", data_st, {dn, {(KEY_W-BLK_W){1'b0}}});
    check("serial_idle_zero", ser_bad, 0);
    check("start_so_count", n_start_so, 1);
    check("start_so_cycle", start_so_c, KEY_W + 1);
    check("decrypt_so_hold", dec_bad, 0);
    check("busy_during_txn", busy_bad, 0);
    check("done_count", n_done, 1);
    check("done_cycle", done_c, exp_done);
  endtask

  task automatic idle_cycles(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ready_si = 1'($urandom_range(0, 1));
      bus.data_si  = 1'($urandom_range(0, 1));
      bus.tag_si   = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int cnt_s, cnt_b;
    rst = 1'b1;
    bus.start = 1'b0; bus.decrypt = 1'b0; bus.key = '0; bus.nonce = '0;
    bus.ad = '0; bus.din = '0; bus.data_si = 1'b0; bus.tag_si = 1'b0; bus.ready_si = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {127'b0, bus.busy}, '0);
    check("rst_done", {127'b0, bus.done}, '0);
    check("rst_err", {127'b0, bus.err}, '0);
    check("rst_dout", {64'b0, bus.dout}, '0);
    check("rst_tag", bus.tag, '0);
    check("rst_serial", {122'b0, bus.key_so, bus.nonce_so, bus.ad_so, bus.data_so,
                         bus.start_so, bus.decrypt_so}, '0);
    rst = 1'b0;
    cnt_s = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.start_so) cnt_s++;
      if (bus.busy) cnt_b++;
      bus.ready_si = 1'($urandom_range(0, 1));
    end
    check("idle_start_so", cnt_s, 0);
    check("idle_busy", cnt_b, 0);

    run_txn(128'h000102030405060708090A0B0C0D0E0F, 128'hF0E0D0C0B0A090807060504030201000,
            64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF, 1'b0, 3,
            64'hDEADBEEFCAFEF00D, 128'h00112233445566778899AABBCCDDEEFF, 0, 1'b0);
    idle_cycles(2);
    run_txn(rnd_key(), rnd_key(), rnd_blk(), rnd_blk(), 1'b1, $urandom_range(0, 5),
            rnd_blk(), rnd_key(), 40, 1'b0);
    idle_cycles(3);
    run_txn(rnd_key(), rnd_key(), rnd_blk(), rnd_blk(), 1'b0, -1,
            rnd_blk(), rnd_key(), 0, 1'b0);
    idle_cycles(1);
    run_txn(rnd_key(), rnd_key(), rnd_blk(), rnd_blk(), 1'b1, $urandom_range(0, 7),
            rnd_blk(), rnd_key(), 0, 1'b0);

    // Start held high: each transaction follows the previous done with no gap.
    for (int t = 0; t < 3; t++)
      run_txn(rnd_key(), rnd_key(), rnd_blk(), rnd_blk(), 1'($urandom_range(0, 1)),
              (t == 1) ? 0 : int'($urandom_range(0, 6)), rnd_blk(), rnd_key(), 0, 1'b1);
    idle_cycles(2);

    // Reset in the middle of the shift phase.
    bus.key = rnd_key(); bus.nonce = rnd_key(); bus.ad = rnd_blk(); bus.din = rnd_blk();
    bus.decrypt = 1'b1; bus.start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {127'b0, bus.busy}, '0);
    check("midrst_serial", {122'b0, bus.key_so, bus.nonce_so, bus.ad_so, bus.data_so,
                            bus.start_so, bus.decrypt_so}, '0);
    check("midrst_results", {bus.done, bus.err, bus.dout != '0, bus.tag != '0}, '0);
    @(negedge clk);
    rst = 1'b0;
    cnt_s = 0; cnt_b = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.start_so) cnt_s++;
      if (bus.busy) cnt_b++;
      bus.ready_si = 1'($urandom_range(0, 1));
    end
    check("midrst_no_start_so", cnt_s, 0);
    check("midrst_stays_idle", cnt_b, 0);

    for (int t = 0; t < 3; t++) begin
      run_txn(rnd_key(), rnd_key(), rnd_blk(), rnd_blk(), 1'($urandom_range(0, 1)),
              $urandom_range(0, 8), rnd_blk(), rnd_key(), 0, 1'b0);
      idle_cycles($urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
